// File: rtl/flash_fetch_ctrl_if.sv
// Core-side fetch channel: request (valid/ready/addr), flush pulse, and response (valid/ready/instr/err).
interface flash_fetch_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_err
    );
endinterface

// File: rtl/flash_fetch_ctrl.sv
// Read-only fetch sequencer for a pair of 16-bit NOR flash parts forming 32-bit instructions.
// Issues the flash reset pulse, then serves one word-aligned fetch at a time with CE#/OE# timing.
//
// state       | meaning
// RST_PULSE   | fl_reset_n held low for RESET_CYCLES
// RST_WAIT    | fl_reset_n high, recovery wait of RECOVERY_CYCLES
// IDLE        | ready for a request, CE#/OE# high
// SETUP       | CE# low, address driven, OE# still high
// ACCESS      | CE#/OE# low for ACCESS_CYCLES, DQ captured on the last edge
// RESP        | response held until rsp_ready
module flash_fetch_ctrl #(
    parameter int unsigned ACCESS_CYCLES   = 7,
    parameter int unsigned RESET_CYCLES    = 50,
    parameter int unsigned RECOVERY_CYCLES = 5,
    parameter logic [31:0] NOP_INSTR       = 32'h00000013
) (
    input  logic                clk,
    input  logic                rst,
    flash_fetch_ctrl_if.slave   bus,
    output logic                fl_ce_n,
    output logic                fl_oe_n,
    output logic                fl_we_n,
    output logic                fl_reset_n,
    output logic                fl_byte_n,
    output logic [18:0]         fl_a,
    input  logic [15:0]         fl_dq_lo,
    input  logic [15:0]         fl_dq_hi
);

    localparam int unsigned MAX_AR  = (ACCESS_CYCLES > RESET_CYCLES) ? ACCESS_CYCLES : RESET_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_AR > RECOVERY_CYCLES) ? MAX_AR : RECOVERY_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // Down-counters load N-1 on state entry and advance on terminal count zero.
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(RECOVERY_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [2:0] {
        S_RST_PULSE,
        S_RST_WAIT,
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [18:0]      fl_a_q, fl_a_d;
    logic [31:0]      rsp_instr_q, rsp_instr_d;
    logic             rsp_err_q, rsp_err_d;
    logic             cnt_zero;
    logic             addr_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RST_PULSE;
            cnt_q       <= RST_LOAD;
            fl_a_q      <= '0;
            rsp_instr_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fl_a_q      <= fl_a_d;
            rsp_instr_q <= rsp_instr_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        fl_a_d        = fl_a_q;
        rsp_instr_d   = rsp_instr_q;
        rsp_err_d     = rsp_err_q;
        fl_reset_n    = 1'b1;
        fl_ce_n       = 1'b1;
        fl_oe_n       = 1'b1;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        cnt_zero      = (cnt_q == '0);
        addr_err      = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:20] != 12'd0);

        case (state_q)
            S_RST_PULSE: begin
                fl_reset_n = 1'b0;
                if (cnt_zero) begin
                    state_d = S_RST_WAIT;
                    cnt_d   = REC_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RST_WAIT: begin
                if (cnt_zero) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_IDLE: begin
                bus.req_ready = ~bus.flush;
                if (bus.req_valid && !bus.flush) begin
                    if (addr_err) begin
                        state_d     = S_RESP;
                        rsp_instr_d = NOP_INSTR;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                        fl_a_d  = {bus.req_addr[19:2], 1'b0};
                    end
                end
            end
            S_SETUP: begin
                fl_ce_n = 1'b0;
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ACCESS;
                    cnt_d   = ACC_LOAD;
                end
            end
            S_ACCESS: begin
                fl_ce_n = 1'b0;
                fl_oe_n = 1'b0;
                // A flush on the final access cycle wins over the capture.
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (cnt_zero) begin
                    state_d     = S_RESP;
                    rsp_instr_d = {fl_dq_hi, fl_dq_lo};
                    rsp_err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.flush || bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_RST_PULSE;
                cnt_d   = RST_LOAD;
            end
        endcase
    end

    assign fl_we_n       = 1'b1;
    assign fl_byte_n     = 1'b1;
    assign fl_a          = fl_a_q;
    assign bus.rsp_instr = rsp_instr_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_flash_fetch_ctrl.sv
// Self-checking bench for flash_fetch_ctrl: timeline-based reference model, directed cases, random traffic.
`timescale 1ns/1ps
module tb_flash_fetch_ctrl;

    localparam int          ACC  = 7;
    localparam int          RSTC = 50;
    localparam int          REC  = 5;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fl_ce_n, fl_oe_n, fl_we_n, fl_reset_n, fl_byte_n;
    logic [18:0] fl_a;
    logic [15:0] fl_dq_lo, fl_dq_hi;

    flash_fetch_ctrl_if bus();

    flash_fetch_ctrl #(
        .ACCESS_CYCLES  (ACC),
        .RESET_CYCLES   (RSTC),
        .RECOVERY_CYCLES(REC),
        .NOP_INSTR      (NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fl_ce_n   (fl_ce_n),
        .fl_oe_n   (fl_oe_n),
        .fl_we_n   (fl_we_n),
        .fl_reset_n(fl_reset_n),
        .fl_byte_n (fl_byte_n),
        .fl_a      (fl_a),
        .fl_dq_lo  (fl_dq_lo),
        .fl_dq_hi  (fl_dq_hi)
    );

    always #5 clk = ~clk;

    // Flash contents: index 4 pinned, everything else a hash of the index.
    function automatic logic [31:0] flash_word(input logic [17:0] idx);
        logic [31:0] h;
        if (idx == 18'd4) return 32'h00100093;
        h = {14'd0, idx} * 32'd2654435761;
        return h ^ 32'h5A5AC3A5;
    endfunction

    logic [31:0] dq_word;
    always_comb begin
        dq_word = 32'hBAD1BAD0;
        if (!fl_ce_n && !fl_oe_n) dq_word = flash_word(fl_a[18:1]);
        fl_dq_lo = dq_word[15:0];
        fl_dq_hi = dq_word[31:16];
    end

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: timestamps of reset release and of the accepted request.
    bit          armed = 1'b0;
    bit          busy  = 1'b0;
    int          t_rel = 0;
    int          t_acc = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_instr = '0;
    logic [18:0] m_fla = '0;

    always @(posedge clk) begin
        if (rst) begin
            armed = 1'b1;
            t_rel = cyc + 1;
            busy  = 1'b0;
            m_fla = '0;
        end else if (armed) begin
            if (!busy) begin
                if (cyc >= t_rel + RSTC + REC && bus.req_valid && !bus.flush) begin
                    busy  = 1'b1;
                    t_acc = cyc;
                    m_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:20] != 12'd0);
                    if (m_err) begin
                        m_instr = NOP;
                    end else begin
                        m_instr = flash_word(bus.req_addr[19:2]);
                        m_fla   = {bus.req_addr[19:2], 1'b0};
                    end
                end
            end else begin
                if (bus.flush) busy = 1'b0;
                else if (cyc >= (m_err ? t_acc + 1 : t_acc + 2 + ACC) && bus.rsp_ready) busy = 1'b0;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        logic e_rstn, e_ce, e_oe, e_rv, e_rr;
        if (armed) begin
            e_rstn = !(cyc < t_rel + RSTC);
            e_rr   = (cyc >= t_rel + RSTC + REC) && !busy && !bus.flush;
            e_ce   = 1'b1;
            e_oe   = 1'b1;
            e_rv   = 1'b0;
            if (busy) begin
                if (m_err) begin
                    e_rv = (cyc >= t_acc + 1);
                end else begin
                    e_ce = !(cyc >= t_acc + 1 && cyc <= t_acc + 1 + ACC);
                    e_oe = !(cyc >= t_acc + 2 && cyc <= t_acc + 1 + ACC);
                    e_rv = (cyc >= t_acc + 2 + ACC);
                end
            end
            check("fl_reset_n", 32'(fl_reset_n), 32'(e_rstn));
            check("fl_ce_n",    32'(fl_ce_n),    32'(e_ce));
            check("fl_oe_n",    32'(fl_oe_n),    32'(e_oe));
            check("req_ready",  32'(bus.req_ready), 32'(e_rr));
            check("rsp_valid",  32'(bus.rsp_valid), 32'(e_rv));
            check("fl_a",       32'(fl_a),       32'(m_fla));
            check("fl_we_n",    32'(fl_we_n),    32'd1);
            check("fl_byte_n",  32'(fl_byte_n),  32'd1);
            if (e_rv) begin
                check("rsp_instr", bus.rsp_instr, m_instr);
                check("rsp_err",   32'(bus.rsp_err), 32'(m_err));
            end
            if (cyc < t_rel + RSTC + REC) begin
                check("rsp_instr_rst", bus.rsp_instr, 32'd0);
                check("rsp_err_rst",   32'(bus.rsp_err), 32'd0);
            end
        end
    end

    // Call at posedge+1 right after rst drops; measures reset pulse and recovery.
    task automatic measure_reset(output int low, output int rdy);
        low = 0;
        rdy = 0;
        @(negedge clk);
        while (!fl_reset_n && low < 200) begin
            low++;
            @(negedge clk);
        end
        while (!bus.req_ready && rdy < 200) begin
            rdy++;
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    // Call at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic issue(input logic [31:0] addr, output int t);
        int n;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("accept_timeout", 32'(n < 200), 32'd1);
        t = cyc;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
    endtask

    task automatic fetch(input logic [31:0] addr, input int hold,
                         output logic [31:0] instr, output logic err, output int lat);
        int t, n;
        issue(addr, t);
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("rsp_timeout", 32'(n < 200), 32'd1);
        lat   = cyc - t;
        instr = bus.rsp_instr;
        err   = bus.rsp_err;
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_instr", bus.rsp_instr, instr);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
            check("bp_ce_n",      32'(fl_ce_n), 32'd1);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          low, rdy, lat, t, seen;
        logic [31:0] instr, addr;
        logic        err;

        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b0;

        // Reset sequence
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        measure_reset(low, rdy);
        check("reset_pulse_len", 32'(low), 32'd50);
        check("recovery_len",    32'(rdy), 32'd5);

        // Single fetch at index 4
        fetch(32'h10, 0, instr, err, lat);
        check("fetch10_lat",   32'(lat), 32'd9);
        check("fetch10_instr", instr, 32'h00100093);
        check("fetch10_err",   32'(err), 32'd0);

        // Back-pressure
        fetch(32'h10, 6, instr, err, lat);
        check("bp_instr", instr, 32'h00100093);

        // Error paths
        fetch(32'h6, 0, instr, err, lat);
        check("mis_lat",   32'(lat), 32'd1);
        check("mis_instr", instr, 32'h00000013);
        check("mis_err",   32'(err), 32'd1);
        fetch(32'h00100000, 0, instr, err, lat);
        check("oor_lat",   32'(lat), 32'd1);
        check("oor_instr", instr, 32'h00000013);
        check("oor_err",   32'(err), 32'd1);

        // Flush mid-ACCESS at T+4
        issue(32'h20, t);
        repeat (3) begin
            @(posedge clk); #1;
        end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_ce_n",  32'(fl_ce_n), 32'd1);
        check("flush_oe_n",  32'(fl_oe_n), 32'd1);
        check("flush_cycle", 32'(cyc - t), 32'd5);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("flush_no_rsp", 32'(seen), 32'd0);
        @(posedge clk); #1;
        fetch(32'h0, 0, instr, err, lat);
        check("idx0_lat",   32'(lat), 32'd9);
        check("idx0_instr", instr, 32'h5A5AC3A5);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            bus.req_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0:       addr = $urandom;
                1:       addr = {12'd0, 18'($urandom), 2'($urandom_range(1, 3))};
                default: addr = {12'd0, 18'($urandom), 2'b00};
            endcase
            bus.req_addr  = addr;
            bus.flush     = ($urandom_range(0, 29) == 0);
            bus.rsp_ready = ($urandom_range(0, 9) < 6);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;

        // rst during ACCESS
        issue(32'h40, t);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ce_n",       32'(fl_ce_n), 32'd1);
        check("rst_oe_n",       32'(fl_oe_n), 32'd1);
        check("rst_fl_a",       32'(fl_a), 32'd0);
        check("rst_fl_reset_n", 32'(fl_reset_n), 32'd0);
        @(posedge clk); #1;
        measure_reset(low, rdy);
        check("rst2_pulse_len", 32'(low + 1), 32'd50);
        check("rst2_recovery",  32'(rdy), 32'd5);
        fetch(32'h10, 0, instr, err, lat);
        check("post_rst_instr", instr, 32'h00100093);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/flash_fetch_ctrl.md
Name: flash_fetch_ctrl

Overview:
Read-only fetch sequencer for the instruction store built from two S29AL008J-style 16-bit flash parts: a lower part holding instr[15:0] and an upper part holding instr[31:16]. It accepts one word-aligned fetch request at a time from the core. It generates the flash reset pulse and the CE#/OE# timing, then returns a 32-bit instruction on a valid/ready response channel. It sits between the core's fetch stage and the top-level flash pins; tri-state DQ handling stays at the top level.

Parameters:
ACCESS_CYCLES, 7, clk cycles OE# held low before DQ is sampled (>=1; 70 ns at 100 MHz).
RESET_CYCLES, 50, clk cycles fl_reset_n held low after rst (>=1).
RECOVERY_CYCLES, 5, clk cycles after fl_reset_n rises before the first access (>=1).
NOP_INSTR, 32'h00000013, instruction returned on an error response.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  fetch request valid.
req_ready  out  1  controller can accept a request.
req_addr  in  32  byte address of the instruction.
flush  in  1  abandon the in-flight fetch (single-cycle pulse).
rsp_valid  out  1  response valid.
rsp_ready  in  1  core accepts the response.
rsp_instr  out  32  fetched instruction.
rsp_err  out  1  misaligned or out-of-range address.
fl_ce_n  out  1  chip enable, shared by both parts.
fl_oe_n  out  1  output enable, shared.
fl_we_n  out  1  write enable; constant 1.
fl_reset_n  out  1  flash reset, shared.
fl_byte_n  out  1  word mode select; constant 1.
fl_a  out  19  flash address, shared.
fl_dq_lo  in  16  DQ of the lower part.
fl_dq_hi  in  16  DQ of the upper part.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - state=RST_PULSE, fl_reset_n=0, fl_ce_n=1, fl_oe_n=1, fl_we_n=1, fl_byte_n=1, fl_a=0.
  - req_ready=0, rsp_valid=0, rsp_instr=0, rsp_err=0.
- RST_PULSE: hold fl_reset_n=0 for RESET_CYCLES cycles, then go to RST_WAIT.
- RST_WAIT: fl_reset_n=1; wait RECOVERY_CYCLES cycles, then go to IDLE.
- IDLE:
  - req_ready = ~flush; CE#/OE# high.
  - On req_valid & req_ready, latch req_addr.
  - If req_addr[1:0]!=0 or req_addr[31:20]!=0, go directly to RESP with rsp_err=1 and rsp_instr=NOP_INSTR; no flash cycle.
  - Otherwise go to SETUP.
- SETUP (1 cycle):
  - fl_ce_n=0, fl_oe_n=1.
  - fl_a = {addr[19:2], 1'b0}: instruction index on A[18:1], A[0]=0.
- ACCESS (ACCESS_CYCLES cycles):
  - fl_ce_n=0, fl_oe_n=0, fl_a held stable.
  - On the clock edge ending the last ACCESS cycle, capture rsp_instr={fl_dq_hi, fl_dq_lo}, set rsp_err=0, go to RESP.
- RESP:
  - fl_ce_n=1, fl_oe_n=1, rsp_valid=1.
  - rsp_instr and rsp_err are held stable until rsp_ready.
  - On rsp_valid & rsp_ready, return to IDLE; rsp_valid=0 next cycle.
- Latency: request accepted in cycle T → rsp_valid first high in cycle T+2+ACCESS_CYCLES (T+9 at default). Error responses: rsp_valid in T+1.
- Throughput: at most one outstanding request. CE# is high for at least 1 cycle (RESP) between consecutive accesses.
- fl_a changes only in IDLE→SETUP; never while fl_oe_n=0.
- flush:
  - In SETUP, ACCESS or RESP: next cycle state=IDLE, CE#/OE# high, rsp_valid=0, no response delivered, captured data discarded.
  - In IDLE: suppresses acceptance that cycle. Flush has priority over req_valid.
  - Flush coincident with the rsp handshake: the handshake completes (response consumed); the state still goes to IDLE.
  - In RST_PULSE/RST_WAIT: ignored.
- rst at any time: immediate return to reset values next cycle, including mid-ACCESS. The full flash reset sequence is reissued.
- Counters are sized for the largest parameter; each counter reloads on state entry.

Test Plan:
- Reset sequence: assert rst 2 cycles → fl_reset_n low exactly 50 cycles, then high; req_ready first high 5 cycles later; CE#/OE# high throughout.
- Single fetch, lower=16'h0093, upper=16'h0010 at index 4: req_addr=32'h10 accepted at T → fl_a=19'h8 from T+1; OE# low T+2..T+8; rsp_valid at T+9 with rsp_instr=32'h00100093, rsp_err=0.
- Back-pressure: rsp_ready held low 6 cycles → rsp_valid and rsp_instr stable, CE# high, req_ready=0; the next request is accepted only after the handshake.
- Error paths:
  - req_addr=32'h6 → rsp_valid at T+1, rsp_err=1, rsp_instr=32'h00000013, CE# never asserted.
  - req_addr=32'h00100000 → same response.
- Flush mid-ACCESS (cycle T+4) → CE#/OE# high at T+5, no rsp_valid. A new request for 32'h0 is then served normally with the data at index 0.
- rst asserted during ACCESS → all outputs return to reset values, the 50-cycle flash reset pulse reappears, and no response is emitted.
